// File: rtl/simon_pkg.sv
// Shared types and constants for the button-press producer and its game-FSM consumer.
package simon_pkg;

   typedef enum logic [1:0] {
      ARMED   = 2'd0,
      PENDING = 2'd1,
      RELEASE = 2'd2
   } press_state_t;

   localparam logic [3:0] BTN_NONE = 4'b0000;
   localparam logic [3:0] BTN0     = 4'b0001;
   localparam logic [3:0] BTN1     = 4'b0010;
   localparam logic [3:0] BTN2     = 4'b0100;
   localparam logic [3:0] BTN3     = 4'b1000;

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-FF synchronizer followed by a stable-level debounce counter.
module btn_debounce_ch #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = 19
) (
   input  logic clk_50M,
   input  logic reset,
   input  logic btn_raw_i,
   output logic stable_o
);

   logic             sync1_q, sync2_q;
   logic             stable_q, stable_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   if ((2 ** CNT_W) <= DEBOUNCE_CYCLES) begin : g_bad_cnt_w
      $error("btn_debounce_ch: CNT_W too narrow for DEBOUNCE_CYCLES");
   end

   // Count only while the synchronized level disagrees with the accepted one;
   // any bounce back to the accepted level restarts the qualification window.
   always_comb begin
      stable_d = stable_q;
      cnt_d    = '0;
      if (sync2_q != stable_q) begin
         if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            stable_d = sync2_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk_50M or posedge reset) begin
      if (reset) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         stable_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         sync1_q  <= btn_raw_i;
         sync2_q  <= sync1_q;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
      end
   end

   assign stable_o = stable_q;

endmodule

// File: rtl/button_press_encoder.sv
// Debounced buttons to one-hot press events with valid/ack hold.
// Optional pending-event timeout is built when PRESS_TIMEOUT_EN is defined.
//
// state   | meaning
// ARMED   | idle, waiting for any debounced rising edge
// PENDING | event held on press_code until a press_ack rising edge
// RELEASE | event consumed, waiting for all buttons to be released
module button_press_encoder
   import simon_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = 19,
   parameter int TIMEOUT_CYCLES  = 100000000
) (
   input  logic       clk_50M,
   input  logic       reset,
   input  logic       b0,
   input  logic       b1,
   input  logic       b2,
   input  logic       b3,
   input  logic       press_ack,
   output logic       press_valid,
   output logic [3:0] press_code,
   output logic       multi_press,
   output logic [3:0] buttons_stable,
   output logic       timeout_pulse
);

   logic [3:0]   btn_raw;
   logic [3:0]   stable;
   logic [3:0]   stable_d_q;
   logic [3:0]   rise;
   logic         ack_q;
   logic         ack_rise;
   logic         timeout_hit;

   press_state_t state_q, state_d;
   logic         valid_q, valid_d;
   logic [3:0]   code_q, code_d;
   logic         multi_q, multi_d;

   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("button_press_encoder: TIMEOUT_CYCLES must be at least 2");
   end

   assign btn_raw = {b3, b2, b1, b0};

   for (genvar i = 0; i < 4; i++) begin : g_ch
      btn_debounce_ch #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .CNT_W          (CNT_W)
      ) u_ch (
         .clk_50M  (clk_50M),
         .reset    (reset),
         .btn_raw_i(btn_raw[i]),
         .stable_o (stable[i])
      );
   end

   assign rise     = stable & ~stable_d_q;
   assign ack_rise = press_ack & ~ack_q;

`ifdef PRESS_TIMEOUT_EN
   localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [TO_W-1:0] tcnt_q, tcnt_d;
   logic            tpulse_q;

   always_comb begin
      tcnt_d      = '0;
      timeout_hit = 1'b0;
      if (state_q == PENDING) begin
         tcnt_d      = tcnt_q + TO_W'(1);
         timeout_hit = (tcnt_q == TO_W'(TIMEOUT_CYCLES - 1));
      end
   end

   always_ff @(posedge clk_50M or posedge reset) begin
      if (reset) begin
         tcnt_q   <= '0;
         tpulse_q <= 1'b0;
      end else begin
         tcnt_q   <= tcnt_d;
         tpulse_q <= timeout_hit & ~ack_rise;
      end
   end

   assign timeout_pulse = tpulse_q;
`else
   assign timeout_hit   = 1'b0;
   assign timeout_pulse = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      valid_d = valid_q;
      code_d  = code_q;
      multi_d = multi_q;
      unique case (state_q)
         ARMED: begin
            // Same-cycle rises merge; an ack arriving here is meaningless and ignored.
            if (rise != BTN_NONE) begin
               valid_d = 1'b1;
               code_d  = rise;
               multi_d = ($countones(rise) > 1);
               state_d = PENDING;
            end
         end
         PENDING: begin
            if (ack_rise || timeout_hit) begin
               valid_d = 1'b0;
               code_d  = BTN_NONE;
               multi_d = 1'b0;
               state_d = RELEASE;
            end
         end
         RELEASE: begin
            if (stable == BTN_NONE) begin
               state_d = ARMED;
            end
         end
         default: begin
            valid_d = 1'b0;
            code_d  = BTN_NONE;
            multi_d = 1'b0;
            state_d = ARMED;
         end
      endcase
   end

   always_ff @(posedge clk_50M or posedge reset) begin
      if (reset) begin
         state_q    <= ARMED;
         valid_q    <= 1'b0;
         code_q     <= BTN_NONE;
         multi_q    <= 1'b0;
         stable_d_q <= BTN_NONE;
         ack_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         valid_q    <= valid_d;
         code_q     <= code_d;
         multi_q    <= multi_d;
         stable_d_q <= stable;
         ack_q      <= press_ack;
      end
   end

   assign press_valid    = valid_q;
   assign press_code     = code_q;
   assign multi_press    = multi_q;
   assign buttons_stable = stable;

endmodule

// File: tb/tb_button_press_encoder.sv
// Directed bench for button_press_encoder with a short debounce window and timeout.
module tb_button_press_encoder;
   import simon_pkg::*;

   logic       clk_50M = 1'b0;
   logic       reset;
   logic       b0, b1, b2, b3;
   logic       press_ack;
   logic       press_valid;
   logic [3:0] press_code;
   logic       multi_press;
   logic [3:0] buttons_stable;
   logic       timeout_pulse;

   int n_checks = 0;
   int n_fail   = 0;

   button_press_encoder #(
      .DEBOUNCE_CYCLES(4),
      .CNT_W          (3),
      .TIMEOUT_CYCLES (20)
   ) dut (
      .clk_50M       (clk_50M),
      .reset         (reset),
      .b0            (b0),
      .b1            (b1),
      .b2            (b2),
      .b3            (b3),
      .press_ack     (press_ack),
      .press_valid   (press_valid),
      .press_code    (press_code),
      .multi_press   (multi_press),
      .buttons_stable(buttons_stable),
      .timeout_pulse (timeout_pulse)
   );

   always #10 clk_50M = ~clk_50M;

   task automatic step(input int n);
      repeat (n) @(negedge clk_50M);
   endtask

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic ack_pulse();
      press_ack = 1'b1;
      step(1);
      chk("ack_clears_valid", {3'b0, press_valid}, 4'b0000);
      chk("ack_clears_code", press_code, BTN_NONE);
      press_ack = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      {b3, b2, b1, b0} = 4'b0000;
      press_ack = 1'b0;
      step(2);
      chk("rst_valid", {3'b0, press_valid}, 4'b0000);
      chk("rst_code", press_code, BTN_NONE);
      chk("rst_multi", {3'b0, multi_press}, 4'b0000);
      chk("rst_stable", buttons_stable, 4'b0000);
      chk("rst_timeout", {3'b0, timeout_pulse}, 4'b0000);
      reset = 1'b0;
      step(2);

      // clean press of b2, exact 7-cycle latency
      b2 = 1'b1;
      step(6);
      chk("clean_not_yet", {3'b0, press_valid}, 4'b0000);
      step(1);
      chk("clean_valid", {3'b0, press_valid}, 4'b0001);
      chk("clean_code", press_code, BTN2);
      chk("clean_multi", {3'b0, multi_press}, 4'b0000);
      chk("clean_stable", buttons_stable, BTN2);
      step(3);
      b2 = 1'b0;
      ack_pulse();
      step(10);
      b2 = 1'b1;
      step(7);
      chk("second_valid", {3'b0, press_valid}, 4'b0001);
      chk("second_code", press_code, BTN2);
      b2 = 1'b0;
      ack_pulse();
      step(10);

      // bouncing b0, then steady
      for (int i = 0; i < 6; i++) begin
         b0 = ~b0;
         step(2);
         chk("bounce_no_event", {3'b0, press_valid}, 4'b0000);
      end
      b0 = 1'b1;
      step(6);
      chk("bounce_not_yet", {3'b0, press_valid}, 4'b0000);
      step(1);
      chk("bounce_valid", {3'b0, press_valid}, 4'b0001);
      chk("bounce_code", press_code, BTN0);
      ack_pulse();
      b0 = 1'b0;
      step(10);

      // held b1 yields one event; b3 while b1 held is swallowed
      b1 = 1'b1;
      step(7);
      chk("hold_valid", {3'b0, press_valid}, 4'b0001);
      chk("hold_code", press_code, BTN1);
      ack_pulse();
      for (int i = 0; i < 50; i++) begin
         step(1);
         chk("hold_no_repeat", {3'b0, press_valid}, 4'b0000);
      end
      b3 = 1'b1;
      step(10);
      chk("hold_b3_ignored", {3'b0, press_valid}, 4'b0000);
      chk("hold_stable", buttons_stable, 4'b1010);
      b1 = 1'b0;
      b3 = 1'b0;
      step(10);
      b3 = 1'b1;
      step(7);
      chk("after_release_valid", {3'b0, press_valid}, 4'b0001);
      chk("after_release_code", press_code, BTN3);
      ack_pulse();
      b3 = 1'b0;
      step(10);

      // simultaneous b0+b3, b1 during PENDING dropped
      b0 = 1'b1;
      b3 = 1'b1;
      step(7);
      chk("simul_code", press_code, 4'b1001);
      chk("simul_multi", {3'b0, multi_press}, 4'b0001);
      b1 = 1'b1;
      step(8);
      chk("drop_valid", {3'b0, press_valid}, 4'b0001);
      chk("drop_code", press_code, 4'b1001);
      chk("drop_stable", buttons_stable, 4'b1011);
      ack_pulse();
      chk("simul_multi_clr", {3'b0, multi_press}, 4'b0000);
      {b3, b2, b1, b0} = 4'b0000;
      step(10);
      chk("simul_idle", {3'b0, press_valid}, 4'b0000);

      // ack held high before the event does not consume it
      press_ack = 1'b1;
      b2 = 1'b1;
      step(7);
      chk("ackheld_valid", {3'b0, press_valid}, 4'b0001);
      step(3);
      chk("ackheld_still", {3'b0, press_valid}, 4'b0001);
      press_ack = 1'b0;
      step(1);
      chk("ack_low_still", {3'b0, press_valid}, 4'b0001);
      press_ack = 1'b1;
      step(1);
      chk("ack_edge_clears", {3'b0, press_valid}, 4'b0000);
      press_ack = 1'b0;
      b2 = 1'b0;
      step(10);

      // async reset while PENDING
      b1 = 1'b1;
      step(7);
      chk("prerst_code", press_code, BTN1);
      reset = 1'b1;
      #1;
      chk("midrst_valid", {3'b0, press_valid}, 4'b0000);
      chk("midrst_code", press_code, BTN_NONE);
      chk("midrst_stable", buttons_stable, 4'b0000);
      step(1);
      reset = 1'b0;
      step(6);
      chk("postrst_not_yet", {3'b0, press_valid}, 4'b0000);
      step(1);
      chk("postrst_valid", {3'b0, press_valid}, 4'b0001);
      chk("postrst_code", press_code, BTN1);

`ifdef PRESS_TIMEOUT_EN
      step(19);
      chk("to_before_valid", {3'b0, press_valid}, 4'b0001);
      chk("to_before_pulse", {3'b0, timeout_pulse}, 4'b0000);
      step(1);
      chk("to_valid_drop", {3'b0, press_valid}, 4'b0000);
      chk("to_code_clr", press_code, BTN_NONE);
      chk("to_pulse", {3'b0, timeout_pulse}, 4'b0001);
      step(1);
      chk("to_pulse_one", {3'b0, timeout_pulse}, 4'b0000);
`else
      step(25);
      chk("noto_valid", {3'b0, press_valid}, 4'b0001);
      chk("noto_pulse", {3'b0, timeout_pulse}, 4'b0000);
      ack_pulse();
`endif
      b1 = 1'b0;
      step(10);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
